// File: rtl/keyscan_irq_if.sv
// Peripheral bus bundle shared with the LED/RGB port: 4-bit address,
// 8-bit write/read data, rw (1 = read) and chip select.
interface keyscan_irq_if;
    logic [3:0] Address;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;

    // CPU side drives the request, peripheral returns read data
    modport master (
        output Address,
        output DI,
        output rw,
        output cs,
        input  DO
    );

    modport slave (
        input  Address,
        input  DI,
        input  rw,
        input  cs,
        output DO
    );
endinterface

// File: rtl/keyscan_irq.sv
// keyscan_irq: switch/key input controller. Synchronises {sw, key},
// debounces each bit on a prescaled sample tick, latches qualifying edges
// into a write-1-to-clear EVENT register and raises a maskable level irq.
module keyscan_irq #(
    parameter int TICK_DIV = 50000,
    parameter int STABLE_N = 4
) (
    input  logic               clk,
    input  logic               rst,
    keyscan_irq_if.slave       bus,
    input  logic [3:0]         sw,
    input  logic [3:0]         key,
    output logic               irq
);

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
    localparam logic [3:0]      CNT_LAST   = 4'(STABLE_N - 1);

    localparam logic [2:0] ADDR_STATE = 3'd0;
    localparam logic [2:0] ADDR_EVENT = 3'd1;
    localparam logic [2:0] ADDR_MASK  = 3'd2;
    localparam logic [2:0] ADDR_CTRL  = 3'd3;

    // Raw input ordering: switches in the upper nibble, keys in the lower
    logic [7:0]        raw_s;
    logic [7:0]        sync1_r;
    logic [7:0]        sync2_r;

    logic [PW-1:0]     presc_r;
    logic              tick_s;

    logic [7:0]        db_r;
    logic [7:0]        db_nxt_s;
    logic [7:0][3:0]   cnt_r;
    logic [7:0][3:0]   cnt_nxt_s;
    logic [7:0]        chg_s;

    logic [7:0]        rise_s;
    logic [7:0]        fall_s;
    logic [7:0]        qual_s;

    logic [7:0]        event_r;
    logic [7:0]        event_nxt_s;
    logic [7:0]        mask_r;
    logic [1:0]        ctrl_r;
    logic              irq_r;

    logic              wr_s;
    logic [2:0]        addr_s;
    logic              wr_event_s;
    logic              wr_mask_s;
    logic              wr_ctrl_s;
    logic [7:0]        w1c_s;
    logic [7:0]        rdata_s;

    // Address[3] is not part of the register decode
    logic              unused_addr_s;

    assign raw_s         = {sw, key};
    assign unused_addr_s = bus.Address[3];
    assign tick_s        = (presc_r == PRESC_LAST);
    assign irq           = irq_r;

    // Two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 8'h00;
            sync2_r <= 8'h00;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Free-running sample prescaler, independent of bus traffic
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PRESC_ONE;
        end
    end

    // Per-bit debounce: count consecutive differing ticks, accept on the STABLE_N-th
    always_comb begin
        db_nxt_s  = db_r;
        cnt_nxt_s = cnt_r;
        chg_s     = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (!tick_s) begin
                cnt_nxt_s[i] = cnt_r[i];
            end else if (sync2_r[i] == db_r[i]) begin
                // A matching sample restarts the run
                cnt_nxt_s[i] = 4'd0;
            end else if (cnt_r[i] == CNT_LAST) begin
                db_nxt_s[i]  = sync2_r[i];
                cnt_nxt_s[i] = 4'd0;
                chg_s[i]     = 1'b1;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + 4'd1;
            end
        end
    end

    // Debounced level and run counters
    always_ff @(posedge clk) begin
        if (rst) begin
            db_r  <= 8'h00;
            cnt_r <= {8{4'd0}};
        end else begin
            db_r  <= db_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    // Edge qualification selected by CTRL[1:0]; 00 and 11 both mean rising
    always_comb begin
        rise_s = chg_s & db_nxt_s;
        fall_s = chg_s & ~db_nxt_s;
        case (ctrl_r)
            2'b01:   qual_s = fall_s;
            2'b10:   qual_s = rise_s | fall_s;
            default: qual_s = rise_s;
        endcase
    end

    // Bus write decode and read-data mux
    always_comb begin
        wr_s       = bus.cs && !bus.rw;
        addr_s     = bus.Address[2:0];
        wr_event_s = 1'b0;
        wr_mask_s  = 1'b0;
        wr_ctrl_s  = 1'b0;
        rdata_s    = 8'h00;
        case (addr_s)
            ADDR_STATE: begin
                rdata_s = db_r;
            end
            ADDR_EVENT: begin
                rdata_s    = event_r;
                wr_event_s = wr_s;
            end
            ADDR_MASK: begin
                rdata_s   = mask_r;
                wr_mask_s = wr_s;
            end
            ADDR_CTRL: begin
                rdata_s   = {6'b000000, ctrl_r};
                wr_ctrl_s = wr_s;
            end
            default: begin
                rdata_s = 8'h00;
            end
        endcase
        if (wr_event_s) begin
            w1c_s = bus.DI;
        end else begin
            w1c_s = 8'h00;
        end
        // Clear first, then set, so a new event on the same edge survives the W1C
        event_nxt_s = (event_r & ~w1c_s) | qual_s;
    end

    // Software-visible registers, read data and interrupt request
    always_ff @(posedge clk) begin
        if (rst) begin
            event_r <= 8'h00;
            mask_r  <= 8'h00;
            ctrl_r  <= 2'b00;
            bus.DO  <= 8'h00;
            irq_r   <= 1'b0;
        end else begin
            event_r <= event_nxt_s;
            if (wr_mask_s) begin
                mask_r <= bus.DI;
            end
            if (wr_ctrl_s) begin
                ctrl_r <= bus.DI[1:0];
            end
            // Any non-write cycle refreshes the read data, as on the LED port
            if (!wr_s) begin
                bus.DO <= rdata_s;
            end
            irq_r <= |(event_r & mask_r);
        end
    end

endmodule

// File: tb/tb_keyscan_irq.sv
// Bench for keyscan_irq: directed scenarios plus random pin and bus traffic,
// checked by a scoreboard fed from a behavioural model of the register file.
module tb_keyscan_irq;

    localparam int TICK_DIV = 4;
    localparam int STABLE_N = 3;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic [3:0] key;
    logic       irq;

    keyscan_irq_if bus ();

    keyscan_irq #(
        .TICK_DIV (TICK_DIV),
        .STABLE_N (STABLE_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .sw  (sw),
        .key (key),
        .irq (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Optional fixed expectation attached to the next read
    bit         c_has;
    logic [7:0] c_val;

    typedef struct {
        logic [7:0] want;
        bit         has_c;
        logic [7:0] cval;
        logic [2:0] addr;
    } rd_t;

    rd_t rdq[$];

    // Behavioural model state
    logic [7:0] m_pipe0, m_pipe1, m_s, m_db, m_event, m_mask, m_qual, m_sel;
    int         m_ctrl;
    int         m_pc;
    int         m_run[8];
    logic       m_irq;
    bit         m_wr;
    int         m_addr;
    rd_t        m_rec;

    // Model: evaluates what the block does at each rising edge
    initial begin : model
        m_pipe0 = 8'h00; m_pipe1 = 8'h00; m_db = 8'h00; m_event = 8'h00;
        m_mask = 8'h00; m_ctrl = 0; m_pc = 0; m_irq = 1'b0;
        foreach (m_run[i]) m_run[i] = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pipe0 = 8'h00; m_pipe1 = 8'h00; m_db = 8'h00; m_event = 8'h00;
                m_mask = 8'h00; m_ctrl = 0; m_pc = 0; m_irq = 1'b0;
                foreach (m_run[i]) m_run[i] = 0;
            end else begin
                m_wr   = bus.cs && !bus.rw;
                m_addr = int'(bus.Address[2:0]);
                case (m_addr)
                    0:       m_sel = m_db;
                    1:       m_sel = m_event;
                    2:       m_sel = m_mask;
                    3:       m_sel = 8'(m_ctrl);
                    default: m_sel = 8'h00;
                endcase
                if (bus.cs && bus.rw) begin
                    m_rec.want  = m_sel;
                    m_rec.has_c = c_has;
                    m_rec.cval  = c_val;
                    m_rec.addr  = bus.Address[2:0];
                    rdq.push_back(m_rec);
                end
                m_irq   = |(m_event & m_mask);
                m_s     = m_pipe1;
                m_pipe1 = m_pipe0;
                m_pipe0 = {sw, key};
                m_qual  = 8'h00;
                if (m_pc == TICK_DIV - 1) begin
                    for (int i = 0; i < 8; i++) begin
                        if (m_s[i] == m_db[i]) begin
                            m_run[i] = 0;
                        end else begin
                            m_run[i]++;
                            if (m_run[i] == STABLE_N) begin
                                m_db[i]  = m_s[i];
                                m_run[i] = 0;
                                if (m_ctrl == 2 || (m_ctrl == 1 && !m_s[i]) ||
                                    (m_ctrl != 1 && m_ctrl != 2 && m_s[i]))
                                    m_qual[i] = 1'b1;
                            end
                        end
                    end
                end
                m_pc = (m_pc + 1) % TICK_DIV;
                if (m_wr && m_addr == 1) m_event = m_event & ~bus.DI;
                m_event = m_event | m_qual;
                if (m_wr && m_addr == 2) m_mask = bus.DI;
                if (m_wr && m_addr == 3) m_ctrl = int'(bus.DI[1:0]);
            end
        end
    end

    // True when the coming edge is a tick that accepts a new level on bit i
    function automatic bit will_accept(input int i);
        return (m_pc == TICK_DIV - 1) && (m_pipe1[i] != m_db[i]) && (m_run[i] == STABLE_N - 1);
    endfunction

    bit   mon_rd;
    rd_t  mon_rec;

    // Monitor: irq every cycle, read data one cycle after each read
    initial begin : monitor
        forever begin
            @(posedge clk);
            mon_rd = bus.cs && bus.rw && !rst;
            @(negedge clk);
            checks++;
            if (irq !== m_irq) begin
                errors++;
                $display("FAIL irq_model: got %0b want %0b at %0t", irq, m_irq, $time);
            end
            if (mon_rd) begin
                checks++;
                if (rdq.size() == 0) begin
                    errors++;
                    $display("FAIL read_queue: DO=%02h but no expectation queued at %0t", bus.DO, $time);
                end else begin
                    mon_rec = rdq.pop_front();
                    if (bus.DO !== mon_rec.want) begin
                        errors++;
                        $display("FAIL read_model addr %0d: got %02h want %02h at %0t",
                                 mon_rec.addr, bus.DO, mon_rec.want, $time);
                    end
                    if (mon_rec.has_c) begin
                        checks++;
                        if (bus.DO !== mon_rec.cval) begin
                            errors++;
                            $display("FAIL read_const addr %0d: got %02h want %02h at %0t",
                                     mon_rec.addr, bus.DO, mon_rec.cval, $time);
                        end
                    end
                end
            end
        end
    end

    // All tasks are entered at a falling edge and return at a falling edge
    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        bus.cs = 1'b1; bus.rw = 1'b0; bus.Address = a; bus.DI = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.rw = 1'b1;
    endtask

    task automatic rd_reg(input logic [3:0] a, input logic [7:0] want);
        bus.cs = 1'b1; bus.rw = 1'b1; bus.Address = a;
        c_has = 1'b1; c_val = want;
        @(negedge clk);
        bus.cs = 1'b0; c_has = 1'b0;
    endtask

    task automatic chk_irq(input logic want);
        checks++;
        if (irq !== want) begin
            errors++;
            $display("FAIL irq_const: got %0b want %0b at %0t", irq, want, $time);
        end
    endtask

    task automatic do_reset();
        sw = 4'h0; key = 4'h0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    bit hit;

    initial begin : stim
        rst = 1'b1; sw = 4'h0; key = 4'h0;
        bus.cs = 1'b0; bus.rw = 1'b1; bus.Address = 4'h0; bus.DI = 8'h00;
        c_has = 1'b0; c_val = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset values and read-back
        for (int a = 0; a < 8; a++) rd_reg(4'(a), 8'h00);
        chk_irq(1'b0);
        wr_reg(4'h2, 8'hA5);
        wr_reg(4'h3, 8'h02);
        rd_reg(4'h2, 8'hA5);
        rd_reg(4'h3, 8'h02);
        wr_reg(4'h0, 8'hFF);
        rd_reg(4'h0, 8'h00);
        rd_reg(4'hA, 8'hA5);
        wr_reg(4'h3, 8'hFF);
        rd_reg(4'h3, 8'h03);

        // Debounce accept on key[0]
        do_reset();
        wr_reg(4'h2, 8'h01);
        key[0] = 1'b1;
        wait_cycles(14);
        rd_reg(4'h0, 8'h01);
        rd_reg(4'h1, 8'h01);
        chk_irq(1'b1);

        // Glitch of two ticks on sw[3] is rejected
        do_reset();
        wr_reg(4'h2, 8'hFF);
        sw[3] = 1'b1;
        wait_cycles(2 * TICK_DIV);
        sw[3] = 1'b0;
        wait_cycles(20);
        rd_reg(4'h0, 8'h00);
        rd_reg(4'h1, 8'h00);
        chk_irq(1'b0);

        // Falling-only mode, then both-edges mode, on key[1]
        do_reset();
        wr_reg(4'h3, 8'h01);
        key[1] = 1'b1;
        wait_cycles(20);
        rd_reg(4'h0, 8'h02);
        rd_reg(4'h1, 8'h00);
        key[1] = 1'b0;
        wait_cycles(20);
        rd_reg(4'h1, 8'h02);
        wr_reg(4'h3, 8'h02);
        wr_reg(4'h1, 8'hFF);
        rd_reg(4'h1, 8'h00);
        key[1] = 1'b1;
        wait_cycles(20);
        rd_reg(4'h1, 8'h02);
        wr_reg(4'h1, 8'h02);
        rd_reg(4'h1, 8'h00);
        key[1] = 1'b0;
        wait_cycles(20);
        rd_reg(4'h1, 8'h02);

        // W1C of one bit, then W1C colliding with a new event
        do_reset();
        key[0] = 1'b1; key[1] = 1'b1;
        wait_cycles(20);
        rd_reg(4'h1, 8'h03);
        wr_reg(4'h1, 8'h01);
        rd_reg(4'h1, 8'h02);
        wr_reg(4'h2, 8'h02);
        wr_reg(4'h3, 8'h02);
        key[1] = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 40 && !hit; n++) begin
            if (will_accept(1)) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL collision_wait: key[1] fall never qualified within 40 cycles");
        end
        wr_reg(4'h1, 8'h02);
        chk_irq(1'b1);
        rd_reg(4'h1, 8'h02);
        chk_irq(1'b1);

        // Reset in the middle of a debounce on sw[0]
        do_reset();
        key[2] = 1'b1;
        wait_cycles(20);
        wr_reg(4'h2, 8'h04);
        rd_reg(4'h1, 8'h04);
        sw[0] = 1'b1;
        hit = 1'b0;
        for (int n = 0; n < 40 && !hit; n++) begin
            if (m_run[4] == 2) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midreset_wait: sw[0] never reached two ticks within 40 cycles");
        end
        chk_irq(1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_irq(1'b0);
        rd_reg(4'h0, 8'h00);
        rd_reg(4'h1, 8'h00);
        rd_reg(4'h2, 8'h00);
        rd_reg(4'h3, 8'h00);
        wait_cycles(6);
        rd_reg(4'h0, 8'h00);
        wait_cycles(4);
        rd_reg(4'h0, 8'h14);

        // Random pins, bus traffic and occasional reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 39) == 0) sw[b]  = ~sw[b];
                if ($urandom_range(0, 39) == 0) key[b] = ~key[b];
            end
            bus.cs      = ($urandom_range(0, 3) != 0);
            bus.rw      = ($urandom_range(0, 2) != 0);
            bus.Address = 4'($urandom);
            bus.DI      = 8'($urandom);
            rst         = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        bus.cs = 1'b0; rst = 1'b0;
        wait_cycles(3);

        checks++;
        if (rdq.size() != 0) begin
            errors++;
            $display("FAIL read_queue_drain: %0d expectations left, want 0", rdq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
